// File: rtl/cavlc_pkg.sv
// Shared definitions for the CAVLC decoder front end.
//   brState_t     : bit-reader FSM state (IDLE, PRIME, RUN, ERR)
//   widthFor()    : bits needed to hold the values 0..maxVal
//   CAVLC_*       : default word/window/depth widths shared with the decode sub-blocks
package cavlc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    RUN   = 2'd2,
    ERR   = 2'd3
  } brState_t;

  localparam int CAVLC_IN_W  = 16;
  localparam int CAVLC_WIN_W = 16;
  localparam int CAVLC_DEPTH = 3;

  function automatic int widthFor(input int maxVal);
    return (maxVal < 2) ? 1 : $clog2(maxVal + 1);
  endfunction

endpackage

// File: rtl/cavlc_funnel_shift.sv
// Combinational funnel for the bit reader buffer.
// Shifts the left-aligned buffer up by shiftAmt (dropping consumed bits) and,
// when insertEn is high, ORs an input word in starting insertPos bits below
// the MSB, i.e. directly under the bits that survive the shift.
//   bufIn     : current buffer contents, MSB = oldest bit
//   shiftAmt  : bits to drop from the top
//   inData    : word to insert, MSB first
//   insertEn  : insert inData this cycle
//   insertPos : number of valid bits left above the insertion point
//   bufOut    : resulting buffer
module cavlc_funnel_shift #(
  parameter int IN_W  = 16,
  parameter int BUF_W = 48,
  parameter int AMT_W = 7
) (
  input  logic [BUF_W-1:0] bufIn,
  input  logic [AMT_W-1:0] shiftAmt,
  input  logic [IN_W-1:0]  inData,
  input  logic             insertEn,
  input  logic [AMT_W-1:0] insertPos,
  output logic [BUF_W-1:0] bufOut
);

  logic [BUF_W-1:0] shifted;
  logic [BUF_W-1:0] word;

  always_comb begin
    shifted = bufIn << shiftAmt;
    word    = '0;
    // Bits below the fill level are zero, so an OR is enough to merge.
    if (insertEn) word = {inData, {(BUF_W - IN_W){1'b0}}} >> insertPos;
    bufOut = shifted | word;
  end

endmodule

// File: rtl/cavlc_bit_reader.sv
// Bitstream front end for the CAVLC decoder. Buffers up to DEPTH input words
// in a left-aligned register and presents an MSB-first lookahead window.
// Each cycle: consume NumShift bits, then (optionally) pad to a byte boundary,
// then append an accepted word below the surviving bits.
//
// Build option: define CAVLC_BITREADER_ALIGN_EN to make AlignReq active;
// otherwise AlignReq is ignored and no pad logic exists.
//
// Ports:
//   Clk, nReset        : clock, asynchronous active-low reset
//   Enable             : low freezes all state and deasserts InReady
//   Flush              : synchronous clear, beats everything except reset
//   InData/InValid/InReady : input word handshake
//   Window/WindowValid : top WIN_W buffer bits, valid when FillBits >= WIN_W
//   ShiftEn/NumShift   : consume request
//   AlignReq           : discard up to the next byte boundary
//   FillBits, BitPos   : buffer occupancy, total bits consumed (wraps)
//   ShiftErr           : sticky error flag
//   DbgState           : FSM state for observation
//
// Handshake: a word transfers on any rising edge where InValid & InReady are
// both high. InReady depends only on Enable and registered state, never on
// InValid or a same-cycle consume. A transferred word is discarded (not
// stored) if Flush is high or the same cycle raises an error.
module cavlc_bit_reader
  import cavlc_pkg::*;
#(
  parameter  int IN_W    = CAVLC_IN_W,
  parameter  int WIN_W   = CAVLC_WIN_W,
  parameter  int DEPTH   = CAVLC_DEPTH,
  parameter  int SHIFT_W = $clog2(WIN_W + 1),
  localparam int BUF_W   = DEPTH * IN_W,
  localparam int FILL_W  = $clog2(BUF_W + 1)
) (
  input  logic               Clk,
  input  logic               nReset,
  input  logic               Enable,
  input  logic               Flush,
  input  logic [IN_W-1:0]    InData,
  input  logic               InValid,
  output logic               InReady,
  output logic [WIN_W-1:0]   Window,
  output logic               WindowValid,
  input  logic               ShiftEn,
  input  logic [SHIFT_W-1:0] NumShift,
  input  logic               AlignReq,
  output logic [FILL_W-1:0]  FillBits,
  output logic [31:0]        BitPos,
  output logic               ShiftErr,
  output brState_t           DbgState
);

  // Wide enough for fill + shift + pad without overflow.
  localparam int CW = widthFor(BUF_W + WIN_W + 8);

  logic [BUF_W-1:0]  bufReg;
  logic [BUF_W-1:0]  bufNext;
  logic [FILL_W-1:0] fillReg;
  logic [31:0]       bitPosReg;
  logic              errReg;
  brState_t          stateReg;

  logic          active;
  logic          shiftReq;
  logic          alignReq;
  logic          stepErr;
  logic          accept;
  logic [CW-1:0] fillExt;
  logic [CW-1:0] shiftAmt;
  logic [CW-1:0] padAmt;
  logic [CW-1:0] totalAmt;
  logic [CW-1:0] remain;
  logic [CW-1:0] newFill;

`ifdef CAVLC_BITREADER_ALIGN_EN
  logic [2:0] lowSum;
`else
  logic unusedAlignReq;
  assign unusedAlignReq = AlignReq;
`endif

  assign Window      = bufReg[BUF_W-1 -: WIN_W];
  assign WindowValid = (fillReg >= FILL_W'(WIN_W));
  assign InReady     = Enable && (stateReg != ERR) && (fillReg <= FILL_W'(BUF_W - IN_W));
  assign FillBits    = fillReg;
  assign BitPos      = bitPosReg;
  assign ShiftErr    = errReg;
  assign DbgState    = stateReg;

  always_comb begin
    fillExt  = CW'(fillReg);
    active   = Enable && !Flush && (stateReg != ERR);
    shiftReq = active && ShiftEn;
    shiftAmt = shiftReq ? CW'(NumShift) : '0;
    alignReq = 1'b0;
    padAmt   = '0;
`ifdef CAVLC_BITREADER_ALIGN_EN
    alignReq = active && AlignReq;
    // Pad counts from the position after this cycle's shift.
    lowSum   = bitPosReg[2:0] + shiftAmt[2:0];
    if (alignReq) padAmt = CW'(3'd0 - lowSum);
`endif
    totalAmt = shiftAmt + padAmt;
    stepErr  = (shiftReq && (NumShift > SHIFT_W'(WIN_W)))
            || ((shiftReq || alignReq) && !WindowValid)
            || (totalAmt > fillExt);
    accept   = InValid && InReady && active && !stepErr;
    remain   = fillExt - totalAmt;
    newFill  = remain + (accept ? CW'(IN_W) : '0);
  end

  cavlc_funnel_shift #(
    .IN_W  (IN_W),
    .BUF_W (BUF_W),
    .AMT_W (CW)
  ) u_funnel (
    .bufIn     (bufReg),
    .shiftAmt  (totalAmt),
    .inData    (InData),
    .insertEn  (accept),
    .insertPos (remain),
    .bufOut    (bufNext)
  );

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      bufReg    <= '0;
      fillReg   <= '0;
      bitPosReg <= '0;
      errReg    <= 1'b0;
      stateReg  <= IDLE;
    end else if (Flush) begin
      bufReg    <= '0;
      fillReg   <= '0;
      bitPosReg <= '0;
      errReg    <= 1'b0;
      stateReg  <= IDLE;
    end else if (Enable && (stateReg != ERR)) begin
      if (stepErr) begin
        // Buffer and position are left exactly as they were.
        errReg   <= 1'b1;
        stateReg <= ERR;
      end else begin
        bufReg    <= bufNext;
        fillReg   <= FILL_W'(newFill);
        bitPosReg <= bitPosReg + 32'(totalAmt);
        case (stateReg)
          IDLE:    stateReg <= PRIME;
          PRIME:   if (newFill >= CW'(WIN_W)) stateReg <= RUN;
          RUN:     if (newFill < CW'(WIN_W)) stateReg <= PRIME;
          default: stateReg <= stateReg;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cavlc_bit_reader.sv
// Self-checking bench for cavlc_bit_reader at IN_W=16, WIN_W=16, DEPTH=3.
// Directed table of steps with hand-derived expected outputs, a few
// hand-written corner sequences, and a random phase checked against a
// bit-queue reference model. Expected values for the AlignReq steps follow
// CAVLC_BITREADER_ALIGN_EN.
module tb_cavlc_bit_reader;
  import cavlc_pkg::*;

  localparam int IN_W = 16, WIN_W = 16, DEPTH = 3, SHIFT_W = 5, FILL_W = 6;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic nReset = 1'b0;
  always #5 clk = ~clk;

  logic               Enable = 1'b0, Flush = 1'b0, InValid = 1'b0, ShiftEn = 1'b0, AlignReq = 1'b0;
  logic [IN_W-1:0]    InData = '0;
  logic [SHIFT_W-1:0] NumShift = '0;
  logic               InReady, WindowValid, ShiftErr;
  logic [WIN_W-1:0]   Window;
  logic [FILL_W-1:0]  FillBits;
  logic [31:0]        BitPos;
  brState_t           DbgState;

  cavlc_bit_reader dut (
    .Clk(clk), .nReset(nReset), .Enable(Enable), .Flush(Flush),
    .InData(InData), .InValid(InValid), .InReady(InReady),
    .Window(Window), .WindowValid(WindowValid),
    .ShiftEn(ShiftEn), .NumShift(NumShift), .AlignReq(AlignReq),
    .FillBits(FillBits), .BitPos(BitPos), .ShiftErr(ShiftErr), .DbgState(DbgState)
  );

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic [15:0] win;
    logic        wv;
    logic [5:0]  fill;
    logic [31:0] pos;
    logic        err;
    logic        rdy;
  } obs_t;

  typedef struct {
    string       name;
    logic        en, fl, iv;
    logic [15:0] d;
    logic        se;
    logic [4:0]  ns;
    logic        al;
    obs_t        exp;
  } vec_t;

  vec_t tbl[$];
  logic [56:0] exp_q[$];
  int total = 0;
  int bad = 0;

  function automatic obs_t mk(input logic [15:0] w, input logic wv, input logic [5:0] f,
                              input logic [31:0] p, input logic e, input logic r);
    obs_t o;
    o.win = w; o.wv = wv; o.fill = f; o.pos = p; o.err = e; o.rdy = r;
    return o;
  endfunction

  function automatic void add(input string nm, input logic en, input logic fl, input logic iv,
                              input logic [15:0] d, input logic se, input logic [4:0] ns,
                              input logic al, input obs_t e);
    vec_t v;
    v.name = nm; v.en = en; v.fl = fl; v.iv = iv; v.d = d;
    v.se = se; v.ns = ns; v.al = al; v.exp = e;
    tbl.push_back(v);
  endfunction

  task automatic check_field(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic compare_obs(input string tag);
    obs_t e;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL %s: got empty scoreboard want an entry", tag);
      return;
    end
    total--;
    e = obs_t'(exp_q.pop_front());
    check_field({tag, ".win"},  32'(Window),      32'(e.win));
    check_field({tag, ".wv"},   32'(WindowValid), 32'(e.wv));
    check_field({tag, ".fill"}, 32'(FillBits),    32'(e.fill));
    check_field({tag, ".pos"},  BitPos,           e.pos);
    check_field({tag, ".err"},  32'(ShiftErr),    32'(e.err));
    check_field({tag, ".rdy"},  32'(InReady),     32'(e.rdy));
  endtask

  // ---------------- driver ----------------
  task automatic apply(input logic en, input logic fl, input logic iv, input logic [15:0] d,
                       input logic se, input logic [4:0] ns, input logic al);
    @(negedge clk);
    Enable = en; Flush = fl; InValid = iv; InData = d;
    ShiftEn = se; NumShift = ns; AlignReq = al;
  endtask

  task automatic run_step(input string name, input logic en, input logic fl, input logic iv,
                          input logic [15:0] d, input logic se, input logic [4:0] ns,
                          input logic al, input obs_t e);
    apply(en, fl, iv, d, se, ns, al);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    compare_obs(name);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    //          name           en fl iv data     se ns  al   win      wv fill pos er rdy
    add("push0",      1, 0, 1, 16'hA5C3, 0, 0,  0, mk(16'hA5C3, 1, 16, 0,  0, 1));
    add("push1",      1, 0, 1, 16'h1234, 0, 0,  0, mk(16'hA5C3, 1, 32, 0,  0, 1));
    add("shift4",     1, 0, 0, 16'h0000, 1, 4,  0, mk(16'h5C31, 1, 28, 4,  0, 1));
    add("hold_en0",   0, 0, 1, 16'hFFFF, 1, 3,  1, mk(16'h5C31, 1, 28, 4,  0, 0));
    add("flush_a",    1, 1, 1, 16'hFFFF, 1, 3,  0, mk(16'h0000, 0, 0,  0,  0, 1));
    add("fill_w0",    1, 0, 1, 16'h1111, 0, 0,  0, mk(16'h1111, 1, 16, 0,  0, 1));
    add("fill_w1",    1, 0, 1, 16'h2222, 0, 0,  0, mk(16'h1111, 1, 32, 0,  0, 1));
    add("fill_w2",    1, 0, 1, 16'h3333, 0, 0,  0, mk(16'h1111, 1, 48, 0,  0, 0));
    add("stall",      1, 0, 1, 16'h4444, 0, 0,  0, mk(16'h1111, 1, 48, 0,  0, 0));
    add("drain16",    1, 0, 1, 16'h4444, 1, 16, 0, mk(16'h2222, 1, 32, 16, 0, 1));
    add("late_acc",   1, 0, 1, 16'h4444, 0, 0,  0, mk(16'h2222, 1, 48, 16, 0, 0));
    add("drain_b",    1, 0, 0, 16'h0000, 1, 16, 0, mk(16'h3333, 1, 32, 32, 0, 1));
    add("drain_c",    1, 0, 0, 16'h0000, 1, 16, 0, mk(16'h4444, 1, 16, 48, 0, 1));
    add("shift0",     1, 0, 0, 16'h0000, 1, 0,  0, mk(16'h4444, 1, 16, 48, 0, 1));
    add("bad17",      1, 0, 1, 16'h5555, 1, 17, 0, mk(16'h4444, 1, 16, 48, 1, 0));
    add("err_hold",   1, 0, 0, 16'h0000, 1, 4,  0, mk(16'h4444, 1, 16, 48, 1, 0));
    add("flush_b",    1, 1, 0, 16'h0000, 0, 0,  0, mk(16'h0000, 0, 0,  0,  0, 1));
    add("starve",     1, 0, 0, 16'h0000, 1, 1,  0, mk(16'h0000, 0, 0,  0,  1, 0));
    add("flush_c",    1, 1, 0, 16'h0000, 0, 0,  0, mk(16'h0000, 0, 0,  0,  0, 1));
    add("al_push0",   1, 0, 1, 16'hA5C3, 0, 0,  0, mk(16'hA5C3, 1, 16, 0,  0, 1));
    add("al_push1",   1, 0, 1, 16'h1234, 0, 0,  0, mk(16'hA5C3, 1, 32, 0,  0, 1));
    add("al_shift3",  1, 0, 0, 16'h0000, 1, 3,  0, mk(16'h2E18, 1, 29, 3,  0, 1));
`ifdef CAVLC_BITREADER_ALIGN_EN
    add("align",      1, 0, 0, 16'h0000, 0, 0,  1, mk(16'hC312, 1, 24, 8,  0, 1));
`else
    add("align",      1, 0, 0, 16'h0000, 0, 0,  1, mk(16'h2E18, 1, 29, 3,  0, 1));
`endif
    add("flush_d",    1, 1, 0, 16'h0000, 0, 0,  0, mk(16'h0000, 0, 0,  0,  0, 1));
    add("mix_push0",  1, 0, 1, 16'hA5C3, 0, 0,  0, mk(16'hA5C3, 1, 16, 0,  0, 1));
    add("mix_push1",  1, 0, 1, 16'h1234, 0, 0,  0, mk(16'hA5C3, 1, 32, 0,  0, 1));
    add("shift5_acc", 1, 0, 1, 16'hBEEF, 1, 5,  0, mk(16'hB862, 1, 43, 5,  0, 0));
    add("mix_sh16",   1, 0, 0, 16'h0000, 1, 16, 0, mk(16'h4697, 1, 27, 21, 0, 1));
    add("mix_sh11",   1, 0, 0, 16'h0000, 1, 11, 0, mk(16'hBEEF, 1, 16, 32, 0, 1));
`ifdef CAVLC_BITREADER_ALIGN_EN
    add("sh_align",   1, 0, 0, 16'h0000, 1, 3,  1, mk(16'hEF00, 0, 8,  40, 0, 1));
    add("al_starve",  1, 0, 0, 16'h0000, 0, 0,  1, mk(16'hEF00, 0, 8,  40, 1, 0));
`else
    add("sh_align",   1, 0, 0, 16'h0000, 1, 3,  1, mk(16'hF778, 0, 13, 35, 0, 1));
    add("al_starve",  1, 0, 0, 16'h0000, 0, 0,  1, mk(16'hF778, 0, 13, 35, 0, 1));
`endif
    add("flush_e",    1, 1, 0, 16'h0000, 0, 0,  0, mk(16'h0000, 0, 0,  0,  0, 1));

    // Reset state, then InReady must rise as soon as Enable does.
    repeat (3) @(posedge clk);
    @(negedge clk);
    nReset = 1'b1;
    #1;
    exp_q.push_back(mk(16'h0000, 0, 0, 0, 0, 0));
    compare_obs("reset");
    check_field("reset.state", 32'(DbgState), 32'(IDLE));
    @(negedge clk);
    Enable = 1'b1;
    #1;
    check_field("rdy_rise", 32'(InReady), 32'd1);

    // Directed table.
    foreach (tbl[i]) begin
      run_step(tbl[i].name, tbl[i].en, tbl[i].fl, tbl[i].iv, tbl[i].d,
               tbl[i].se, tbl[i].ns, tbl[i].al, tbl[i].exp);
      if (tbl[i].name == "bad17") check_field("bad17.state", 32'(DbgState), 32'(ERR));
      if (tbl[i].name == "flush_b") check_field("flush_b.state", 32'(DbgState), 32'(IDLE));
    end

    // Random phase against a bit-queue model (all requests kept legal).
    begin
      bit          mq[$];
      int unsigned mpos;
      mpos = 0;
      for (int n = 0; n < 400; n++) begin
        logic        en, fl, iv, se, al;
        logic [15:0] d;
        logic [4:0]  ns;
        int          sh, pad, mfill;
        obs_t        e;
        fl = ($urandom_range(0, 59) == 0);
        en = ($urandom_range(0, 7) != 0);
        iv = ($urandom_range(0, 2) != 0);
        d  = 16'($urandom);
        mfill = mq.size();
        se = (mfill >= WIN_W) && ($urandom_range(0, 2) != 0);
        ns = 5'($urandom_range(0, WIN_W));
        al = (mfill >= WIN_W) && ($urandom_range(0, 3) == 0);
        if (al && ns > 9) ns = 5'd9;
        if (fl) begin
          mq.delete();
          mpos = 0;
        end else if (en) begin
          sh  = se ? int'(ns) : 0;
          pad = 0;
`ifdef CAVLC_BITREADER_ALIGN_EN
          if (al) pad = (8 - int'((mpos + sh) % 8)) % 8;
`endif
          for (int k = 0; k < sh + pad; k++) void'(mq.pop_front());
          mpos += sh + pad;
          if (iv && mfill <= 32) for (int b = IN_W - 1; b >= 0; b--) mq.push_back(d[b]);
        end
        for (int b = 0; b < WIN_W; b++) e.win[WIN_W-1-b] = (b < mq.size()) ? mq[b] : 1'b0;
        e.wv   = (mq.size() >= WIN_W);
        e.fill = 6'(mq.size());
        e.pos  = mpos;
        e.err  = 1'b0;
        e.rdy  = en && (mq.size() <= 32);
        run_step("rand", en, fl, iv, d, se, ns, al, e);
      end
    end

    // Asynchronous reset in the middle of a cycle with data buffered.
    run_step("pre_rst_fl", 1, 1, 0, 16'h0000, 0, 0, 0, mk(16'h0000, 0, 0,  0, 0, 1));
    run_step("pre_rst_p0", 1, 0, 1, 16'hCAFE, 0, 0, 0, mk(16'hCAFE, 1, 16, 0, 0, 1));
    run_step("pre_rst_p1", 1, 0, 1, 16'hF00D, 1, 2, 0, mk(16'h2BFB, 1, 30, 2, 0, 1));
    #2;
    nReset = 1'b0;
    Enable = 1'b0;
    #1;
    exp_q.push_back(mk(16'h0000, 0, 0, 0, 0, 0));
    compare_obs("async_rst");
    check_field("async_rst.state", 32'(DbgState), 32'(IDLE));
    check_field("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
